// File: rtl/bitrev_reorder_buf.sv
// Ping-pong reorder buffer: one frame written in natural index order, drained in bit-reversed order.
// Optional feature macro BITREV_NATURAL_EN adds rd_natural to drain a frame in natural order.
`ifndef D_width
`define D_width 32
`endif

module bitrev_reorder_buf #(
  parameter int unsigned RADIX_K1 = 2,
  parameter int unsigned L_MAX    = 6,
  parameter int unsigned DATA_W   = `D_width
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [2:0]                cfg_l,
`ifdef BITREV_NATURAL_EN
  input  logic                      rd_natural,
`endif
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic [RADIX_K1*L_MAX-1:0] out_idx,
  output logic                      out_last
);

  localparam int unsigned AW    = RADIX_K1 * L_MAX;
  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned MW    = AW + 1;

  typedef enum logic {R_IDLE, R_STREAM} rstate_e;

  // Clamp the frame-size selector into the legal range 1..L_MAX.
  function automatic logic [2:0] eff_l(input logic [2:0] l);
    logic [2:0] r;
    r = l;
    if (l == 3'd0) r = 3'd1;
    else if (l > 3'(L_MAX)) r = 3'(L_MAX);
    return r;
  endfunction

  // N-1 for a frame of size 2^(RADIX_K1*l).
  function automatic logic [AW-1:0] last_idx(input logic [2:0] l);
    logic [AW-1:0] ones;
    ones = '1;
    return ones >> (AW - RADIX_K1 * 32'(l));
  endfunction

  // Reverse the low RADIX_K1*l bits; j is always below N so upper bits are zero.
  function automatic logic [AW-1:0] rev_w(input logic [AW-1:0] j, input logic [2:0] l);
    logic [AW-1:0] r;
    for (int unsigned i = 0; i < AW; i++) r[i] = j[AW-1-i];
    return r >> (AW - RADIX_K1 * 32'(l));
  endfunction

  rstate_e         state_q, state_d;
  logic            wbank_q, wbank_d;
  logic            rbank_q, rbank_d;
  logic [AW-1:0]   wcnt_q, wcnt_d;
  logic [MW-1:0]   rcnt_q, rcnt_d;
  logic [1:0]      full_q, full_d;
  logic [1:0][2:0] lat_l_q, lat_l_d;
  logic            out_valid_q, out_valid_d;
  logic [AW-1:0]   out_idx_q, out_idx_d;
  logic            out_last_q, out_last_d;
  logic [DATA_W-1:0] out_data_q;

  logic            wr_en_c;
  logic            wr_last_c;
  logic [2:0]      wr_l_c;
  logic [2:0]      rd_l_c;
  logic [AW-1:0]   rd_max_c;
  logic [AW-1:0]   rd_j_c;
  logic [AW-1:0]   rd_addr_c;
  logic            space_c;
  logic            hs_last_c;
  logic            issue_c;
  logic            clr_full_c;
  logic            rd_nat_c;

  logic [DATA_W-1:0] mem_q [2*DEPTH];

`ifdef BITREV_NATURAL_EN
  logic [1:0] nat_q, nat_d;

  always_comb begin
    nat_d = nat_q;
    if (wr_en_c && (wcnt_q == '0)) nat_d[wbank_q] = rd_natural;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) nat_q <= '0;
    else      nat_q <= nat_d;
  end

  assign rd_nat_c = nat_q[rbank_q];
`else
  assign rd_nat_c = 1'b0;
`endif

  // Write side: sequential fill of the current write bank.
  always_comb begin
    in_ready  = !full_q[wbank_q];
    wr_l_c    = (wcnt_q == '0) ? eff_l(cfg_l) : lat_l_q[wbank_q];
    wr_en_c   = in_valid && in_ready;
    wr_last_c = wr_en_c && (wcnt_q == last_idx(wr_l_c));
    wbank_d   = wbank_q;
    wcnt_d    = wcnt_q;
    lat_l_d   = lat_l_q;
    if (wr_en_c) begin
      wcnt_d = wcnt_q + AW'(1);
      if (wcnt_q == '0) lat_l_d[wbank_q] = wr_l_c;
      if (wr_last_c) begin
        wcnt_d  = '0;
        wbank_d = ~wbank_q;
      end
    end
  end

  // Read FSM: beat 0 is issued straight from R_IDLE to keep first-read latency at one cycle.
  always_comb begin
    rd_l_c     = lat_l_q[rbank_q];
    rd_max_c   = last_idx(rd_l_c);
    space_c    = !out_valid_q || out_ready;
    hs_last_c  = out_valid_q && out_ready && out_last_q;
    state_d    = state_q;
    rbank_d    = rbank_q;
    rcnt_d     = rcnt_q;
    issue_c    = 1'b0;
    rd_j_c     = '0;
    clr_full_c = 1'b0;
    case (state_q)
      R_IDLE: begin
        if (full_q[rbank_q] && space_c) begin
          issue_c = 1'b1;
          rcnt_d  = MW'(1);
          state_d = R_STREAM;
        end
      end
      R_STREAM: begin
        if (space_c && (rcnt_q <= {1'b0, rd_max_c})) begin
          issue_c = 1'b1;
          rd_j_c  = rcnt_q[AW-1:0];
          rcnt_d  = rcnt_q + MW'(1);
        end
        if (hs_last_c) begin
          clr_full_c = 1'b1;
          rbank_d    = ~rbank_q;
          rcnt_d     = '0;
          state_d    = R_IDLE;
        end
      end
      default: state_d = R_IDLE;
    endcase
    rd_addr_c = rd_nat_c ? rd_j_c : rev_w(rd_j_c, rd_l_c);
  end

  // Full flags: set by the writer, cleared by the reader, never on the same bank in one cycle.
  always_comb begin
    full_d = full_q;
    if (wr_last_c)  full_d[wbank_q] = 1'b1;
    if (clr_full_c) full_d[rbank_q] = 1'b0;
  end

  // Output register holds while stalled; it only reloads when the beat ahead has left.
  always_comb begin
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    out_last_d  = out_last_q;
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
    if (issue_c) begin
      out_valid_d = 1'b1;
      out_idx_d   = rd_addr_c;
      out_last_d  = (rd_j_c == rd_max_c);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= R_IDLE;
      wbank_q     <= 1'b0;
      rbank_q     <= 1'b0;
      wcnt_q      <= '0;
      rcnt_q      <= '0;
      full_q      <= '0;
      lat_l_q     <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wbank_q     <= wbank_d;
      rbank_q     <= rbank_d;
      wcnt_q      <= wcnt_d;
      rcnt_q      <= rcnt_d;
      full_q      <= full_d;
      lat_l_q     <= lat_l_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_c) mem_q[{wbank_q, wcnt_q}] <= in_data;
  end

  // Synchronous RAM read lands directly in the output data register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         out_data_q <= '0;
    else if (issue_c) out_data_q <= mem_q[{rbank_q, rd_addr_c}];
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_bitrev_reorder_buf.sv
// Directed bench for bitrev_reorder_buf with a scoreboard of expected output beats.
module tb_bitrev_reorder_buf;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 12;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [AW-1:0] idx;
    logic          last;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    cfg_l;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_idx;
  logic          out_last;
`ifdef BITREV_NATURAL_EN
  logic          rd_natural;
`endif

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];

  bitrev_reorder_buf dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_l     (cfg_l),
`ifdef BITREV_NATURAL_EN
    .rd_natural(rd_natural),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input bit ok);
    checks++;
    if (!ok) begin
      failures++;
      $error("FAIL %s", tag);
    end
  endtask

  // Output monitor on the falling edge: pop and compare each handshake, check stall stability.
  logic          stalled = 1'b0;
  logic [DW-1:0] hold_data;
  logic [AW-1:0] hold_idx;
  logic          hold_last;

  always @(negedge clk) begin
    exp_t e;
    if (rst !== 1'b1) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        chk("stall_valid", out_valid === 1'b1);
        chk("stall_data", out_data === hold_data);
        chk("stall_idx", out_idx === hold_idx);
        chk("stall_last", out_last === hold_last);
      end
      if (out_valid && out_ready) begin
        chk("spurious_beat", sb.size() > 0);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("out_data", out_data === e.data);
          chk("out_idx", out_idx === e.idx);
          chk("out_last", out_last === e.last);
        end
      end
      stalled   = out_valid && !out_ready;
      hold_data = out_data;
      hold_idx  = out_idx;
      hold_last = out_last;
    end
  end

  function automatic int tb_rev(input int j, input int w);
    int r;
    r = 0;
    for (int b = 0; b < w; b++) if (((j >> b) & 1) == 1) r = r | (1 << (w - 1 - b));
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic [2:0] l, input bit nat, input bit chk_ready);
    int t;
    t = 0;
    step();
    in_valid = 1'b1;
    in_data  = d;
    cfg_l    = l;
`ifdef BITREV_NATURAL_EN
    rd_natural = nat;
`endif
    if (chk_ready) chk("in_ready_free_bank", in_ready === 1'b1);
    while (!in_ready && t < 1000) begin
      step();
      t++;
    end
    if (t >= 1000) chk("in_ready_timeout", in_ready === 1'b1);
  endtask

  task automatic send_frame(input int l, input int base, input bit nat, input bit chk_ready);
    int lp;
    int w;
    int n;
    int a;
    lp = (l == 0) ? 1 : ((l > 6) ? 6 : l);
    w  = 2 * lp;
    n  = 1 << w;
    for (int j = 0; j < n; j++) begin
      a = nat ? j : tb_rev(j, w);
      sb.push_back('{data: DW'(base + a), idx: AW'(a), last: (j == n - 1)});
    end
    for (int i = 0; i < n; i++) send_beat(DW'(base + i), 3'(l), nat, chk_ready);
  endtask

  task automatic drain(input bit rnd, input string tag);
    int t;
    t = 0;
    while (sb.size() != 0 && t < 5000) begin
      step();
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      t++;
    end
    out_ready = 1'b1;
    chk(tag, sb.size() == 0);
  endtask

  initial begin
    int  t1[16];
    bit  hs;
    int  t;
    t1 = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
    rst       = 1'b0;
    cfg_l     = 3'd0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
`ifdef BITREV_NATURAL_EN
    rd_natural = 1'b0;
`endif
    repeat (3) step();
    chk("rst_out_valid", out_valid === 1'b0);
    chk("rst_out_last", out_last === 1'b0);
    chk("rst_out_data", out_data === 32'h0);
    chk("rst_out_idx", out_idx === 12'h0);
    chk("rst_in_ready", in_ready === 1'b1);
    rst = 1'b1;

    // 16-point bit-reversed order against a literal table, plus first-beat latency.
    for (int i = 0; i < 16; i++)
      sb.push_back('{data: DW'(t1[i]), idx: AW'(t1[i]), last: (i == 15)});
    for (int i = 0; i < 16; i++) send_beat(DW'(i), 3'd2, 1'b0, 1'b1);
    step();
    in_valid = 1'b0;
    chk("t1_valid_at_T1", out_valid === 1'b0);
    step();
    chk("t1_valid_at_T2", out_valid === 1'b1);
    drain(1'b0, "t1_drain");

    // Back-to-back frames of different sizes.
    send_frame(1, 0, 1'b0, 1'b1);
    send_frame(2, 0, 1'b0, 1'b1);
    step();
    in_valid = 1'b0;
    drain(1'b0, "t2_drain");

    // Both banks full under full backpressure, then release.
    out_ready = 1'b0;
    send_frame(1, 0, 1'b0, 1'b1);
    send_frame(1, 4, 1'b0, 1'b1);
    step();
    in_valid = 1'b0;
    chk("t3_in_ready_both_full", in_ready === 1'b0);
    repeat (3) step();
    chk("t3_in_ready_still_full", in_ready === 1'b0);
    out_ready = 1'b1;
    hs = 1'b0;
    t  = 0;
    while (!hs && t < 50) begin
      hs = out_valid && out_ready && out_last;
      step();
      t++;
    end
    chk("t3_last_handshake_seen", hs == 1'b1);
    chk("t3_in_ready_after_release", in_ready === 1'b1);
    drain(1'b0, "t3_drain");

    // 64-point frame with random output backpressure.
    send_frame(3, 1000, 1'b0, 1'b1);
    step();
    in_valid = 1'b0;
    drain(1'b1, "t4_drain");

    // Reset after 7 accepted beats of a 16-point frame, then a clean frame.
    for (int i = 0; i < 7; i++) send_beat(DW'(500 + i), 3'd2, 1'b0, 1'b1);
    step();
    in_valid = 1'b0;
    rst = 1'b0;
    #2;
    chk("t5_rst_out_valid", out_valid === 1'b0);
    chk("t5_rst_out_last", out_last === 1'b0);
    chk("t5_rst_out_data", out_data === 32'h0);
    chk("t5_rst_out_idx", out_idx === 12'h0);
    chk("t5_rst_in_ready", in_ready === 1'b1);
    step();
    rst = 1'b1;
    send_frame(2, 200, 1'b0, 1'b1);
    step();
    in_valid = 1'b0;
    drain(1'b0, "t5_drain");

`ifdef BITREV_NATURAL_EN
    // Natural-order drain with the same latency as the bit-reversed case.
    send_frame(2, 0, 1'b1, 1'b1);
    step();
    in_valid = 1'b0;
    chk("t6_valid_at_T1", out_valid === 1'b0);
    step();
    chk("t6_valid_at_T2", out_valid === 1'b1);
    drain(1'b0, "t6_drain");
`endif

    repeat (10) step();
    chk("final_no_extra_beats", out_valid === 1'b0);
    chk("final_sb_empty", sb.size() == 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
